div_unit: RTL and testbench

- Iterative radix-2 integer divider in the execute stage. Implements RV32M DIV, DIVU, REM and REMU.
- Produces the div_valid / divresult pair that the execute stage registers into MEM1. MEM1 selects that pair when aluop is DIV.
- Holds busy high while it computes, so the hazard unit can stall IF/ID/EX. Holds its result until the pipeline advances.

---
 rtl/div_unit.sv | 177 +++++++++++++++++
 tb/tb_div_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
`default_nettype none
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
//            Signed operands are divided as magnitudes and the sign is fixed
//            up on the final cycle. Divide-by-zero and signed overflow finish
//            straight away without iterating.
// Ports    : clk, reset (async, active-high)
//            req/op/dividend/divisor - start request and operands
//            kill                    - abandon the EX-slot operation
//            ack                     - downstream register captures the result
//            busy                    - stall request to the hazard unit
//            div_valid/divresult     - final result, held until ack
// Revision : 1.0 - initial release
// ============================================================================
module div_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            kill,
    input  logic            ack,
    output logic            busy,
    output logic            div_valid,
    output logic [XLEN-1:0] divresult
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0] C_MIN = {1'b1, {(XLEN-1){1'b0}}};

    state_t            state_q, state_d;
    logic              rsel_q, rsel_d;      // 1 = remainder result
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   dvs_q, dvs_d;
    logic [XLEN-1:0]   res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Operand decode for a possible acceptance this cycle
    logic              w_accept;
    logic              w_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_abs;
    logic [XLEN-1:0]   w_b_abs;
    logic              w_div_zero;
    logic              w_ovf;

    // One restoring step
    logic [XLEN:0]     w_rem_sh;
    logic [XLEN:0]     w_trial;
    logic [XLEN-1:0]   w_res_final;

    assign w_accept   = ((state_q == S_IDLE) || ((state_q == S_DONE) && ack))
                        && req && !kill;
    assign w_signed   = ~op[0];
    assign w_a_neg    = w_signed & dividend[XLEN-1];
    assign w_b_neg    = w_signed & divisor[XLEN-1];
    assign w_a_abs    = w_a_neg ? -dividend : dividend;
    assign w_b_abs    = w_b_neg ? -divisor : divisor;
    assign w_div_zero = (divisor == '0);
    assign w_ovf      = w_signed && (dividend == C_MIN) && (&divisor);

    // Shifted partial remainder carries the next dividend bit; the extra top
    // bit makes the trial subtraction's borrow visible as a sign bit.
    assign w_rem_sh   = {rem_q, quo_q[XLEN-1]};
    assign w_trial    = w_rem_sh - {1'b0, dvs_q};

    assign w_res_final = rsel_q ? (rneg_q ? -rem_q : rem_q)
                                : (qneg_q ? -quo_q : quo_q);

    // Busy rises in the acceptance cycle so EX stalls without a bubble;
    // special cases complete on the acceptance edge and never stall.
    assign busy      = (state_q == S_CALC) || (w_accept && !w_div_zero && !w_ovf);
    assign div_valid = (state_q == S_DONE);
    assign divresult = div_valid ? res_q : '0;

    always_comb begin
        state_d = state_q;
        rsel_d  = rsel_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        res_d   = res_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_CALC: begin
                if (cnt_q != '0) begin
                    if (!w_trial[XLEN]) begin
                        rem_d = w_trial[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b1};
                    end else begin
                        rem_d = w_rem_sh[XLEN-1:0];
                        quo_d = {quo_q[XLEN-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    res_d   = w_res_final;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (ack) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A new operation may start from IDLE or from the DONE/ack cycle.
        if (w_accept) begin
            rsel_d = op[1];
            qneg_d = w_a_neg ^ w_b_neg;
            rneg_d = w_a_neg;
            if (w_div_zero) begin
                res_d   = op[1] ? dividend : '1;
                state_d = S_DONE;
            end else if (w_ovf) begin
                res_d   = op[1] ? '0 : C_MIN;
                state_d = S_DONE;
            end else begin
                rem_d   = '0;
                quo_d   = w_a_abs;
                dvs_d   = w_b_abs;
                cnt_d   = CNT_W'(XLEN);
                state_d = S_CALC;
            end
        end

        if (kill) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            rsel_q  <= 1'b0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rsel_q  <= rsel_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_div_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit. Expected results are queued
//            when an operation is issued and compared when div_valid rises.
// Revision : 1.0 - initial release
// ============================================================================
module tb_div_unit;

    localparam int XLEN = 32;
    localparam int NORM_LAT = XLEN + 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            req;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            kill;
    logic            ack;
    wire             busy;
    wire             div_valid;
    wire  [XLEN-1:0] divresult;

    int n_checks = 0;
    int n_pass   = 0;
    logic [XLEN-1:0] exp_q [$];

    div_unit #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .dividend  (dividend),
        .divisor   (divisor),
        .kill      (kill),
        .ack       (ack),
        .busy      (busy),
        .div_valid (div_valid),
        .divresult (divresult)
    );

    always #5 clk = ~clk;

    // Reference model of the RV32M division semantics
    function automatic logic [XLEN-1:0] model(input logic [1:0] o,
                                              input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        logic signed [XLEN-1:0] sa;
        logic signed [XLEN-1:0] sb;
        sa = a;
        sb = b;
        if (b == 0) return o[1] ? a : {XLEN{1'b1}};
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return o[1] ? 32'h0 : 32'h8000_0000;
        case (o)
            2'd0:    return sa / sb;
            2'd1:    return a / b;
            2'd2:    return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Presents a request in the cycle before the next edge, records busy in
    // that acceptance cycle, and queues the expected result.
    task automatic start(input logic [1:0] o, input logic [XLEN-1:0] a,
                         input logic [XLEN-1:0] b, output logic acc_busy);
        @(negedge clk);
        req = 1'b1; op = o; dividend = a; divisor = b;
        #1 acc_busy = busy;
        @(posedge clk);
        exp_q.push_back(model(o, a, b));
        #1 req = 1'b0;
    endtask

    // Counts edges from acceptance to div_valid (0 = valid right after the
    // acceptance edge) and busy samples on the way; -1 on timeout.
    task automatic wait_valid(input int limit, output int cyc, output int busy_n);
        cyc = -1;
        busy_n = 0;
        for (int i = 0; i <= limit; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (div_valid) begin
                cyc = i;
                break;
            end
            if (busy) busy_n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; op = 2'd0; dividend = '0; divisor = '0;
        kill = 1'b0; ack = 1'b1;
        #12;
        n_checks++;
        if ({busy, div_valid, divresult} !== {1'b0, 1'b0, 32'h0})
            $display("FAIL reset_outputs: busy=%b valid=%b result=%h, required 0/0/0",
                     busy, div_valid, divresult);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Issues one operation with ack high and checks latency, busy and result.
    task automatic run_op(input string name, input logic [1:0] o,
                          input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        logic acc_busy;
        int cyc, bn, lat, bexp;
        logic [XLEN-1:0] exp;
        logic special;
        special = (b == 0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
        lat  = special ? 0 : NORM_LAT;
        bexp = special ? 0 : NORM_LAT;
        start(o, a, b, acc_busy);
        wait_valid(60, cyc, bn);
        n_checks++;
        if (cyc !== lat) $display("FAIL %s_latency: got %0d, required %0d", name, cyc, lat);
        else n_pass++;
        n_checks++;
        if ({acc_busy, 32'(bn)} !== {!special, 32'(bexp)})
            $display("FAIL %s_busy: accept_busy=%b cycles=%0d, required %b/%0d",
                     name, acc_busy, bn, !special, bexp);
        else n_pass++;
        if (cyc >= 0 && exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (divresult !== exp) $display("FAIL %s_result: got %h, required %h", name, divresult, exp);
            else n_pass++;
        end else begin
            exp_q.delete();
        end
        @(posedge clk); #1;
        n_checks++;
        if (div_valid !== 1'b0) $display("FAIL %s_release: div_valid=%b, required 0", name, div_valid);
        else n_pass++;
    endtask

    task automatic test_basic();
        run_op("divu_100_7", 2'd1, 32'd100, 32'd7);
        run_op("rem_m7_2",   2'd2, 32'hFFFF_FFF9, 32'd2);
        run_op("div_m7_2",   2'd0, 32'hFFFF_FFF9, 32'd2);
    endtask

    task automatic test_special();
        run_op("div_ovf",  2'd0, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("rem_ovf",  2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("divu_z",   2'd1, 32'd5, 32'd0);
        run_op("remu_z",   2'd3, 32'd5, 32'd0);
        run_op("div_z",    2'd0, 32'hFFFF_FFF0, 32'd0);
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            logic [1:0] o;
            logic [XLEN-1:0] a, b;
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = (k == 5) ? 32'd1 : ($urandom >> $urandom_range(0, 28));
            run_op("random", o, a, b);
        end
    endtask

    task automatic test_back_to_back();
        logic acc_busy;
        int cyc, bn;
        logic [XLEN-1:0] exp;
        ack = 1'b0;
        start(2'd1, 32'd100, 32'd7, acc_busy);
        wait_valid(60, cyc, bn);
        n_checks++;
        if (cyc !== NORM_LAT) $display("FAIL hold_latency: got %0d, required %0d", cyc, NORM_LAT);
        else n_pass++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (divresult !== exp) $display("FAIL hold_result: got %h, required %h", divresult, exp);
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({div_valid, divresult} !== {1'b1, 32'd14})
                $display("FAIL hold_stable: valid=%b result=%h, required 1/0000000e", div_valid, divresult);
            else n_pass++;
        end
        ack = 1'b1;
        start(2'd1, 32'd9, 32'd3, acc_busy);
        n_checks++;
        if (acc_busy !== 1'b1) $display("FAIL b2b_accept_busy: got %b, required 1", acc_busy);
        else n_pass++;
        wait_valid(60, cyc, bn);
        n_checks++;
        if ({32'(cyc), 32'(bn)} !== {32'(NORM_LAT), 32'(NORM_LAT)})
            $display("FAIL b2b_latency: latency=%0d busy=%0d, required %0d/%0d", cyc, bn, NORM_LAT, NORM_LAT);
        else n_pass++;
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            n_checks++;
            if (divresult !== exp) $display("FAIL b2b_result: got %h, required %h", divresult, exp);
            else n_pass++;
        end
        @(posedge clk); #1;
    endtask

    task automatic test_kill();
        logic acc_busy;
        logic seen;
        start(2'd0, 32'd1000, 32'd3, acc_busy);
        repeat (9) @(posedge clk);
        @(negedge clk);
        kill = 1'b1;
        @(posedge clk);
        #1 kill = 1'b0;
        n_checks++;
        if ({busy, div_valid} !== 2'b00)
            $display("FAIL kill_idle: busy=%b valid=%b, required 0/0", busy, div_valid);
        else n_pass++;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL kill_no_result: div_valid rose=%b, required 0", seen);
        else n_pass++;
        exp_q.delete();
    endtask

    task automatic test_async_reset();
        logic acc_busy;
        logic seen;
        int cyc, bn;
        start(2'd1, 32'd100, 32'd7, acc_busy);
        repeat (5) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b1) $display("FAIL rst_precond_busy: got %b, required 1", busy);
        else n_pass++;
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({busy, div_valid, divresult} !== {1'b0, 1'b0, 32'h0})
            $display("FAIL rst_mid_calc: busy=%b valid=%b result=%h, required 0/0/0",
                     busy, div_valid, divresult);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (div_valid || busy) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) $display("FAIL rst_no_result: activity=%b, required 0", seen);
        else n_pass++;

        // Reset while a result is being held
        ack = 1'b0;
        start(2'd3, 32'd100, 32'd7, acc_busy);
        wait_valid(60, cyc, bn);
        exp_q.delete();
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({div_valid, divresult} !== {1'b0, 32'h0})
            $display("FAIL rst_in_done: valid=%b result=%h, required 0/0", div_valid, divresult);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        ack = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_random();
        test_back_to_back();
        test_kill();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
